predictor_input_queue: RTL and testbench
========================================

PREDICTOR_INPUT_QUEUE -- requirements
Module: predictor_input_queue

Interface
REQ-001 Parameter ADDR_W, default 11, width of jump_addr and branch_addr.
REQ-002 Parameter BR_W, default 14, width of branch.
REQ-003 Parameter DATA_W, default 16, width of W.
REQ-004 Parameter DEPTH, default 4, record slots; power of two, >= 2.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 jump_addr, branch, branch_addr, W, CY  in  ADDR_W/BR_W/ADDR_W/DATA_W/1  record fields sampled on push.
REQ-008 exec_done  in  1  push strobe; one record per high cycle.
REQ-009 out_ready  in  1  consumer accepts the head record.
REQ-010 clear_ovf  in  1  clears the sticky overflow flag.
REQ-011 out_valid  out  1  head record present.
REQ-012 out_jump_addr, out_branch, out_branch_addr, out_W, out_CY  out  field widths  head record fields.
REQ-013 level  out  $clog2(DEPTH)+1  records held.
REQ-014 full, empty  out  1 each  level==DEPTH, level==0.
REQ-015 overflow  out  1  sticky: a push was dropped.

Function
REQ-016 Push SHALL occur when exec_done=1 and (full=0 or a pop occurs the same cycle).
REQ-017 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-018 Order SHALL be strict FIFO; records SHALL be unmodified.
REQ-019 A record pushed into an empty queue SHALL appear on out_* with out_valid=1 one cycle after the push edge (registered, show-ahead).
REQ-020 Simultaneous push and pop SHALL leave level unchanged, including at full and at level 1.
REQ-021 exec_done=1 with full=1 and no pop SHALL drop the incoming record, leave contents unchanged, and set overflow=1 on the next edge.
REQ-022 overflow SHALL stay 1 until clear_ovf=1 or reset; if clear_ovf and a drop coincide, overflow SHALL remain 1.
REQ-023 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor go negative.
REQ-024 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 When empty, out_* data SHALL hold the last popped value (don't-care for checking); out_valid=0.

Reset
REQ-026 reset=1 SHALL set pointers, level, out_valid, overflow and all out_* data to 0, full=0, empty=1 on the next edge.
REQ-027 reset SHALL take priority over push, pop and clear_ovf; contents in flight SHALL be discarded.
REQ-028 Storage array contents need not be reset.

Configuration
REQ-029 Macro PRED_QUEUE_OVF_CNT_EN defined: extra output ovf_count (8 bits) SHALL count dropped pushes, saturating at 255, cleared by reset or clear_ovf (a coinciding drop loads 1).
REQ-030 Macro undefined: port ovf_count and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared package pred_pkg SHALL hold the default width constants and a packed record typedef pred_rec_t {jump_addr, branch, branch_addr, W, CY}.
REQ-032 Storage SHALL be a sub-module pred_queue_mem (DEPTH x record, one write port, one read port, no reset).
REQ-033 Pointer, level, overflow logic SHALL live in predictor_input_queue.

Verification
REQ-034 Reset, single push jump_addr=0x155,W=0xBEEF,CY=1, out_ready=0 -> next cycle out_valid=1, out_W=0xBEEF, level=1.
REQ-035 Four pushes (W=1..4), out_ready=0 -> full=1, level=4; pop all -> W sequence 1,2,3,4, then empty=1.
REQ-036 Full, exec_done=1 with W=9, out_ready=0 -> overflow=1, level=4, popped sequence excludes 9; clear_ovf pulse -> overflow=0.
REQ-037 Full, exec_done=1 and out_ready=1 same cycle -> level stays 4, new record emerges last.
REQ-038 Reset asserted at level=3 -> next cycle level=0, out_valid=0, overflow=0; a push afterwards returns only the new record.
REQ-039 With PRED_QUEUE_OVF_CNT_EN: 300 drops while full -> ovf_count=255.

Source files
------------

// File: rtl/predictor_input_queue_pkg.sv
// Shared widths and record layout for the predictor input queue.
// Build option: PRED_QUEUE_OVF_CNT_EN adds an 8-bit dropped-push counter.
package pred_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int BR_W_DEF   = 14;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] jump_addr;
    logic [BR_W_DEF-1:0]   branch;
    logic [ADDR_W_DEF-1:0] branch_addr;
    logic [DATA_W_DEF-1:0] W;
    logic                  CY;
  } pred_rec_t;

  // Flat record width, field order as in pred_rec_t (jump_addr MSB, CY LSB).
  function automatic int rec_w(input int addr_w, input int br_w, input int data_w);
    return 2*addr_w + br_w + data_w + 1;
  endfunction
endpackage

// File: rtl/predictor_input_queue_if.sv
// Producer/consumer bundle of the predictor input queue.
// Build option: PRED_QUEUE_OVF_CNT_EN adds ovf_count.
interface predictor_input_queue_if
  import pred_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BR_W   = BR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              exec_done;
  logic [ADDR_W-1:0] jump_addr;
  logic [BR_W-1:0]   branch;
  logic [ADDR_W-1:0] branch_addr;
  logic [DATA_W-1:0] W;
  logic              CY;
  logic              out_ready;
  logic              clear_ovf;

  logic              out_valid;
  logic [ADDR_W-1:0] out_jump_addr;
  logic [BR_W-1:0]   out_branch;
  logic [ADDR_W-1:0] out_branch_addr;
  logic [DATA_W-1:0] out_W;
  logic              out_CY;
  logic [LW-1:0]     level;
  logic              full;
  logic              empty;
  logic              overflow;
`ifdef PRED_QUEUE_OVF_CNT_EN
  logic [7:0]        ovf_count;

  modport master (
    output exec_done, jump_addr, branch, branch_addr, W, CY, out_ready, clear_ovf,
    input  out_valid, out_jump_addr, out_branch, out_branch_addr, out_W, out_CY,
    input  level, full, empty, overflow, ovf_count
  );
  modport slave (
    input  exec_done, jump_addr, branch, branch_addr, W, CY, out_ready, clear_ovf,
    output out_valid, out_jump_addr, out_branch, out_branch_addr, out_W, out_CY,
    output level, full, empty, overflow, ovf_count
  );
`else
  modport master (
    output exec_done, jump_addr, branch, branch_addr, W, CY, out_ready, clear_ovf,
    input  out_valid, out_jump_addr, out_branch, out_branch_addr, out_W, out_CY,
    input  level, full, empty, overflow
  );
  modport slave (
    input  exec_done, jump_addr, branch, branch_addr, W, CY, out_ready, clear_ovf,
    output out_valid, out_jump_addr, out_branch, out_branch_addr, out_W, out_CY,
    output level, full, empty, overflow
  );
`endif
endinterface

// File: rtl/predictor_input_queue_mem.sv
// Record storage: DEPTH slots, one synchronous write port, one async read port, no reset.
module pred_queue_mem
  import pred_pkg::*;
#(
  parameter int REC_W = rec_w(ADDR_W_DEF, BR_W_DEF, DATA_W_DEF),
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [REC_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [REC_W-1:0] o_rdata
);
  logic [REC_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/predictor_input_queue.sv
// Show-ahead record FIFO with registered head and sticky overflow.
// Build option: PRED_QUEUE_OVF_CNT_EN adds a saturating dropped-push counter.
module predictor_input_queue
  import pred_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BR_W   = BR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  predictor_input_queue_if.slave  q
);
  localparam int REC_W = rec_w(ADDR_W, BR_W, DATA_W);
  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;
  localparam int O_BA  = DATA_W + 1;
  localparam int O_BR  = O_BA + ADDR_W;
  localparam int O_JA  = O_BR + BR_W;

  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_out_valid;
  logic [REC_W-1:0] r_out;
  logic             r_ovf;

  logic             w_full, w_pop, w_push, w_drop;
  logic [PW-1:0]    w_rd_nxt;
  logic [LW-1:0]    w_lvl_nxt, w_remain;
  logic [REC_W-1:0] w_in_rec, w_mem_rd;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_pop     = r_out_valid & q.out_ready;
  assign w_push    = q.exec_done & (~w_full | w_pop);
  assign w_drop    = q.exec_done & w_full & ~w_pop;
  assign w_rd_nxt  = r_rd_ptr + PW'(w_pop);
  assign w_remain  = r_level - LW'(w_pop);
  assign w_lvl_nxt = w_remain + LW'(w_push);
  assign w_in_rec  = {q.jump_addr, q.branch, q.branch_addr, q.W, q.CY};

  pred_queue_mem #(.REC_W(REC_W), .DEPTH(DEPTH)) u_mem (
    .clock   (clock),
    .i_we    (w_push & ~reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_in_rec),
    .i_raddr (w_rd_nxt),
    .o_rdata (w_mem_rd)
  );

  // Head register is loaded with the record that will be at the front after this
  // edge: an older stored record if any survive the pop, else the incoming one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push);
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_lvl_nxt;
      if (w_lvl_nxt != '0) begin
        r_out_valid <= 1'b1;
        r_out       <= (w_remain != '0) ? w_mem_rd : w_in_rec;
      end else begin
        r_out_valid <= 1'b0;
      end
      if (w_drop)           r_ovf <= 1'b1;
      else if (q.clear_ovf) r_ovf <= 1'b0;
    end
  end

`ifdef PRED_QUEUE_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clock) begin
    if (reset)                         r_ovf_cnt <= '0;
    else if (q.clear_ovf)              r_ovf_cnt <= {7'd0, w_drop};
    else if (w_drop && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
  end

  assign q.ovf_count = r_ovf_cnt;
`endif

  assign q.out_valid       = r_out_valid;
  assign q.out_CY          = r_out[0];
  assign q.out_W           = r_out[DATA_W:1];
  assign q.out_branch_addr = r_out[O_BR-1:O_BA];
  assign q.out_branch      = r_out[O_JA-1:O_BR];
  assign q.out_jump_addr   = r_out[REC_W-1:O_JA];
  assign q.level           = r_level;
  assign q.full            = w_full;
  assign q.empty           = (r_level == '0);
  assign q.overflow        = r_ovf;
endmodule

// File: tb/tb_predictor_input_queue.sv
// Self-checking bench: directed table, hand sequences, and random traffic vs a queue model.
module tb_predictor_input_queue;
  import pred_pkg::*;

  localparam int DEPTH = DEPTH_DEF;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  predictor_input_queue_if #(.DEPTH(DEPTH)) qif ();

  predictor_input_queue #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .q     (qif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  pred_rec_t mq[$];
  bit        m_ovf;
  int        m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic pred_rec_t rnd_rec();
    pred_rec_t r;
    r.jump_addr   = 11'($urandom);
    r.branch      = 14'($urandom);
    r.branch_addr = 11'($urandom);
    r.W           = 16'($urandom);
    r.CY          = 1'($urandom);
    return r;
  endfunction

  function automatic pred_rec_t w_rec(input logic [15:0] w);
    pred_rec_t r;
    r = '0;
    r.W = w;
    r.jump_addr = 11'(w * 3);
    r.CY = w[0];
    return r;
  endfunction

  // Drive one cycle of stimulus, advance the model, land 1 time unit after the edge.
  task automatic step(input bit ed, input bit rdy, input bit clr, input bit rst, input pred_rec_t r);
    bit pop, drop;
    reset           = rst;
    qif.exec_done   = ed;
    qif.out_ready   = rdy;
    qif.clear_ovf   = clr;
    qif.jump_addr   = r.jump_addr;
    qif.branch      = r.branch;
    qif.branch_addr = r.branch_addr;
    qif.W           = r.W;
    qif.CY          = r.CY;
    @(posedge clock);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      pop  = (mq.size() > 0) && rdy;
      drop = ed && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (ed && !drop) mq.push_back(r);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (clr) m_cnt = drop ? 1 : 0;
      else if (drop && m_cnt < 255) m_cnt++;
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    pred_rec_t o;
    o = {qif.out_jump_addr, qif.out_branch, qif.out_branch_addr, qif.out_W, qif.out_CY};
    chk({tag, ".valid"}, 64'(qif.out_valid), 64'(mq.size() > 0));
    chk({tag, ".level"}, 64'(qif.level), 64'(mq.size()));
    chk({tag, ".full"},  64'(qif.full),  64'(mq.size() == DEPTH));
    chk({tag, ".empty"}, 64'(qif.empty), 64'(mq.size() == 0));
    chk({tag, ".ovf"},   64'(qif.overflow), 64'(m_ovf));
    if (mq.size() > 0) chk({tag, ".head"}, 64'(o), 64'(mq[0]));
`ifdef PRED_QUEUE_OVF_CNT_EN
    chk({tag, ".cnt"}, 64'(qif.ovf_count), 64'(m_cnt));
`endif
  endtask

  typedef struct {
    bit          ed, rdy, clr;
    logic [15:0] w;
    bit          ev;
    int          elvl;
    logic [15:0] ew;
    bit          eovf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    pred_rec_t r0, rb;
    r0 = '0;

    // fill, drop W=9, clear, drain; refill, push+pop at full, drain
    tbl = '{
      '{1,0,0, 16'd1, 1,1, 16'd1, 0},
      '{1,0,0, 16'd2, 1,2, 16'd1, 0},
      '{1,0,0, 16'd3, 1,3, 16'd1, 0},
      '{1,0,0, 16'd4, 1,4, 16'd1, 0},
      '{1,0,0, 16'd9, 1,4, 16'd1, 1},
      '{0,0,1, 16'd0, 1,4, 16'd1, 0},
      '{0,1,0, 16'd0, 1,3, 16'd2, 0},
      '{0,1,0, 16'd0, 1,2, 16'd3, 0},
      '{0,1,0, 16'd0, 1,1, 16'd4, 0},
      '{0,1,0, 16'd0, 0,0, 16'd0, 0},
      '{1,0,0, 16'd5, 1,1, 16'd5, 0},
      '{1,0,0, 16'd6, 1,2, 16'd5, 0},
      '{1,0,0, 16'd7, 1,3, 16'd5, 0},
      '{1,0,0, 16'd8, 1,4, 16'd5, 0},
      '{1,1,0, 16'd10,1,4, 16'd6, 0},
      '{0,1,0, 16'd0, 1,3, 16'd7, 0},
      '{0,1,0, 16'd0, 1,2, 16'd8, 0},
      '{0,1,0, 16'd0, 1,1, 16'd10,0},
      '{0,1,0, 16'd0, 0,0, 16'd0, 0}
    };

    // Reset state
    step(0, 0, 0, 1, r0);
    step(0, 0, 0, 1, r0);
    chk("rst.valid", 64'(qif.out_valid), 0);
    chk("rst.level", 64'(qif.level), 0);
    chk("rst.empty", 64'(qif.empty), 1);
    chk("rst.full",  64'(qif.full), 0);
    chk("rst.ovf",   64'(qif.overflow), 0);
    chk("rst.outW",  64'(qif.out_W), 0);
    chk("rst.outJA", 64'(qif.out_jump_addr), 0);

    // Single push into empty queue, visible next cycle
    rb = '0; rb.jump_addr = 11'h155; rb.W = 16'hBEEF; rb.CY = 1'b1;
    step(1, 0, 0, 0, rb);
    chk("p1.valid", 64'(qif.out_valid), 1);
    chk("p1.W",     64'(qif.out_W), 64'hBEEF);
    chk("p1.JA",    64'(qif.out_jump_addr), 64'h155);
    chk("p1.CY",    64'(qif.out_CY), 1);
    chk("p1.level", 64'(qif.level), 1);
    step(0, 0, 0, 0, r0);
    chk("p1.hold",  64'(qif.out_W), 64'hBEEF);
    step(0, 1, 0, 0, r0);
    chk("p1.empty", 64'(qif.empty), 1);

    // Table-driven sequence
    step(0, 0, 0, 1, r0);
    foreach (tbl[i]) begin
      step(tbl[i].ed, tbl[i].rdy, tbl[i].clr, 0, w_rec(tbl[i].w));
      chk($sformatf("tbl%0d.valid", i), 64'(qif.out_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d.level", i), 64'(qif.level), 64'(tbl[i].elvl));
      chk($sformatf("tbl%0d.full", i),  64'(qif.full),  64'(tbl[i].elvl == 4));
      chk($sformatf("tbl%0d.ovf", i),   64'(qif.overflow), 64'(tbl[i].eovf));
      if (tbl[i].ev) chk($sformatf("tbl%0d.W", i), 64'(qif.out_W), 64'(tbl[i].ew));
      chk_model($sformatf("tbl%0d", i));
    end

    // Reset at level 3 with overflow set and a push pending
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, w_rec(16'(20 + i)));
    step(1, 0, 0, 0, w_rec(16'd99));
    step(0, 1, 0, 0, r0);
    chk("r3.level", 64'(qif.level), 3);
    chk("r3.ovf",   64'(qif.overflow), 1);
    step(1, 1, 1, 1, w_rec(16'd77));
    chk("r3.rlevel", 64'(qif.level), 0);
    chk("r3.rvalid", 64'(qif.out_valid), 0);
    chk("r3.rovf",   64'(qif.overflow), 0);
    step(1, 0, 0, 0, w_rec(16'd55));
    chk("r3.newW",   64'(qif.out_W), 55);
    chk("r3.newlvl", 64'(qif.level), 1);
    step(0, 1, 0, 0, r0);
    chk("r3.empty",  64'(qif.empty), 1);

    // Sustained drops while full, then clear coinciding with a drop
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, rnd_rec());
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0, rnd_rec());
    chk("drop.ovf",   64'(qif.overflow), 1);
    chk("drop.level", 64'(qif.level), 4);
`ifdef PRED_QUEUE_OVF_CNT_EN
    chk("drop.cnt",   64'(qif.ovf_count), 255);
`endif
    step(1, 0, 1, 0, rnd_rec());
    chk("clrdrop.ovf", 64'(qif.overflow), 1);
`ifdef PRED_QUEUE_OVF_CNT_EN
    chk("clrdrop.cnt", 64'(qif.ovf_count), 1);
`endif
    step(0, 0, 1, 0, r0);
    chk("clr.ovf", 64'(qif.overflow), 0);
    chk_model("drop");

    // Random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 2), rnd_rec());
      chk_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
